// File: rtl/ofifo_drain_ctrl.sv
// ofifo_drain_ctrl: pops NUM_VEC psum vectors from the output FIFO into consecutive pmem addresses.
// Build option OFIFO_DRAIN_RELU_EN clamps negative psum lanes to zero on the write path.
module ofifo_drain_ctrl #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int addr_w  = 11,
    parameter int NUM_VEC = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [addr_w-1:0]      base_addr,
    input  logic                   ofifo_valid,
    input  logic [col*psum_bw-1:0] ofifo_out,
    output logic                   ofifo_rd,
    output logic                   pmem_cen,
    output logic                   pmem_wen,
    output logic [addr_w-1:0]      pmem_addr,
    output logic [col*psum_bw-1:0] pmem_d,
    output logic                   busy,
    output logic                   done
);

    localparam int               CNT_W    = $clog2(NUM_VEC + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VEC);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FIN
    } state_t;

    state_t                 state;
    state_t                 state_n;
    logic [CNT_W-1:0]       count;
    logic [addr_w-1:0]      base_q;
    logic [col*psum_bw-1:0] wr_data;
    logic                   pop;

`ifdef OFIFO_DRAIN_RELU_EN
    always_comb begin
        wr_data = ofifo_out;
        for (int unsigned i = 0; i < col; i++) begin
            if (ofifo_out[i*psum_bw + psum_bw - 1]) begin
                wr_data[i*psum_bw +: psum_bw] = '0;
            end
        end
    end
`else
    assign wr_data = ofifo_out;
`endif

    // DRAIN is left one cycle after the final pop, so the last write strobe is on
    // the bus while done is pending and start stays blocked until the FIN cycle ends.
    always_comb begin
        state_n = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                pop = ofifo_valid && (count < LAST_CNT);
                if (count == LAST_CNT) begin
                    state_n = FIN;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign ofifo_rd = pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            base_q    <= '0;
            pmem_cen  <= 1'b1;
            pmem_wen  <= 1'b1;
            pmem_addr <= '0;
            pmem_d    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state    <= state_n;
            busy     <= (state_n != IDLE);
            done     <= (state_n == FIN);
            pmem_cen <= ~pop;
            pmem_wen <= ~pop;
            if ((state == IDLE) && start) begin
                base_q <= base_addr;
                count  <= '0;
            end
            if (pop) begin
                pmem_d    <= wr_data;
                pmem_addr <= base_q + addr_w'(count);
                count     <= count + 1'b1;
            end
        end
    end

endmodule
